// File: rtl/pen_servo_ramp.sv
// Pen-servo command stage: accepts pen-up/down commands, slews the PWM high-time
// toward the target once per frame, waits a settle interval, then reports completion.
module pen_servo_ramp #(
  parameter int SYS_FREQ      = 50000000,
  parameter int PWM_FREQ      = 50,
  parameter int UP_WIDTH      = 50000,
  parameter int DOWN_WIDTH    = 200000,
  parameter int STEP          = 10000,
  parameter int SETTLE_FRAMES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_pen_down,
  output logic        cmd_ready,
  output logic [19:0] pulse_width,
  output logic        frame_tick,
  output logic        busy,
  output logic        done,
  output logic        pen_is_down
);

  localparam int FRAME = SYS_FREQ / PWM_FREQ;
  localparam logic [19:0] FRAME_LAST = 20'(FRAME - 1);
  localparam logic [19:0] UP_W       = 20'(UP_WIDTH);
  localparam logic [19:0] DOWN_W     = 20'(DOWN_WIDTH);
  localparam logic [19:0] STEP_W     = 20'(STEP);
  localparam int SCW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_FRAMES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RAMP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]     state;
  logic [19:0]    frame_cnt;
  logic [19:0]    frame_cnt_next;
  logic [19:0]    target;
  logic           target_down;
  logic [SCW-1:0] settle_cnt;
  logic [19:0]    cmd_target;
  logic [19:0]    distance;
  logic           moving_up;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cmd_target = cmd_pen_down ? DOWN_W : UP_W;

  always_comb begin
    frame_cnt_next = (frame_cnt == FRAME_LAST) ? 20'd0 : frame_cnt + 20'd1;
  end

  // Tick is registered off the next count so it lines up with count == FRAME-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt  <= 20'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= frame_cnt_next;
      frame_tick <= (frame_cnt_next == FRAME_LAST);
    end
  end

  // Magnitude is taken before stepping so the width never wraps.
  always_comb begin
    moving_up = (target > pulse_width);
    distance  = moving_up ? (target - pulse_width) : (pulse_width - target);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pulse_width <= UP_W;
      pen_is_down <= 1'b0;
      done        <= 1'b0;
      target      <= UP_W;
      target_down <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target      <= cmd_target;
            target_down <= cmd_pen_down;
            if (cmd_target == pulse_width) begin
              done        <= 1'b1;
              pen_is_down <= cmd_pen_down;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (frame_tick) begin
            if (distance <= STEP_W) begin
              pulse_width <= target;
              settle_cnt  <= '0;
              state       <= SETTLE;
            end else if (moving_up) begin
              pulse_width <= pulse_width + STEP_W;
            end else begin
              pulse_width <= pulse_width - STEP_W;
            end
          end
        end
        SETTLE: begin
          if (frame_tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              state       <= IDLE;
              done        <= 1'b1;
              pen_is_down <= target_down;
            end else begin
              settle_cnt <= settle_cnt + SCW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pen_servo_ramp.sv
// Bench for pen_servo_ramp: directed vector table, hand-written corner sequences,
// and randomized commands/resets checked against a planned-trajectory model.
module tb_pen_servo_ramp;

  localparam int SYS_F    = 1000;
  localparam int PWM_F    = 100;
  localparam int FRAME    = SYS_F / PWM_F;
  localparam int UP_W     = 50;
  localparam int DOWN_W   = 200;
  localparam int STEP_W   = 40;
  localparam int SETTLE_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_pen_down = 1'b0;
  logic        cmd_ready;
  logic [19:0] pulse_width;
  logic        frame_tick;
  logic        busy;
  logic        done;
  logic        pen_is_down;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: on acceptance, the whole per-tick width plan is queued up front.
  int m_pw;
  int m_pen;
  int m_done;
  int m_target_down;
  int m_q[$];

  typedef struct {
    int cyc;
    int valid;
    int down;
    int pw;
    int tick;
    int ready;
    int busy;
    int done;
    int pen;
  } vec_t;

  vec_t vecs[$];
  int   seen[$];
  int   exp_up[$];

  pen_servo_ramp #(
    .SYS_FREQ(SYS_F), .PWM_FREQ(PWM_F), .UP_WIDTH(UP_W), .DOWN_WIDTH(DOWN_W),
    .STEP(STEP_W), .SETTLE_FRAMES(SETTLE_N)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_pen_down(cmd_pen_down),
    .cmd_ready(cmd_ready), .pulse_width(pulse_width), .frame_tick(frame_tick),
    .busy(busy), .done(done), .pen_is_down(pen_is_down)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic void check_output(string name, int pw, int tk, int rd, int bz, int dn, int pn);
    n_cmp++;
    if (int'(pulse_width) != pw || int'(frame_tick) != tk || int'(cmd_ready) != rd ||
        int'(busy) != bz || int'(done) != dn || int'(pen_is_down) != pn) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got pw=%0d tick=%0d ready=%0d busy=%0d done=%0d pen=%0d want pw=%0d tick=%0d ready=%0d busy=%0d done=%0d pen=%0d",
               name, cyc, pulse_width, frame_tick, cmd_ready, busy, done, pen_is_down,
               pw, tk, rd, bz, dn, pn);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_pw = UP_W;
    m_pen = 0;
    m_done = 0;
    m_target_down = 0;
    m_q.delete();
  endfunction

  function automatic void model_advance();
    int tgt;
    int w;
    int nd;
    nd = 0;
    if (m_q.size() != 0) begin
      if ((cyc % FRAME) == FRAME - 1) begin
        m_pw = m_q.pop_front();
        if (m_q.size() == 0) begin
          nd = 1;
          m_pen = m_target_down;
        end
      end
    end else if (cmd_valid) begin
      tgt = cmd_pen_down ? DOWN_W : UP_W;
      m_target_down = cmd_pen_down ? 1 : 0;
      if (tgt == m_pw) begin
        nd = 1;
        m_pen = m_target_down;
      end else begin
        w = m_pw;
        while (w != tgt) begin
          if (((tgt > w) ? tgt - w : w - tgt) <= STEP_W) w = tgt;
          else w = (tgt > w) ? w + STEP_W : w - STEP_W;
          m_q.push_back(w);
        end
        for (int i = 0; i < SETTLE_N; i++) m_q.push_back(tgt);
      end
    end
    m_done = nd;
  endfunction

  function automatic void check_model(string name);
    check_output(name, m_pw, ((cyc % FRAME) == FRAME - 1) ? 1 : 0,
                 (m_q.size() == 0) ? 1 : 0, (m_q.size() != 0) ? 1 : 0, m_done, m_pen);
  endfunction

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset takes effect immediately; release lands one tick past a rising edge (cycle 0).
  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_output("reset_async", UP_W, 0, 1, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to(string name, int c);
    while (cyc < c) begin
      check_model(name);
      step();
    end
  endtask

  task automatic apply_stimulus();
    vec_t v;
    int prev;
    int got_done;

    vecs.push_back('{0,  0, 0,  50, 0, 1, 0, 0, 0});
    vecs.push_back('{3,  1, 1,  50, 0, 1, 0, 0, 0});
    vecs.push_back('{4,  0, 0,  50, 0, 0, 1, 0, 0});
    vecs.push_back('{9,  0, 0,  50, 1, 0, 1, 0, 0});
    vecs.push_back('{10, 0, 0,  90, 0, 0, 1, 0, 0});
    vecs.push_back('{12, 1, 0,  90, 0, 0, 1, 0, 0});
    vecs.push_back('{19, 0, 0,  90, 1, 0, 1, 0, 0});
    vecs.push_back('{20, 0, 0, 130, 0, 0, 1, 0, 0});
    vecs.push_back('{29, 0, 0, 130, 1, 0, 1, 0, 0});
    vecs.push_back('{30, 0, 0, 170, 0, 0, 1, 0, 0});
    vecs.push_back('{39, 0, 0, 170, 1, 0, 1, 0, 0});
    vecs.push_back('{40, 0, 0, 200, 0, 0, 1, 0, 0});
    vecs.push_back('{49, 0, 0, 200, 1, 0, 1, 0, 0});
    vecs.push_back('{50, 0, 0, 200, 0, 0, 1, 0, 0});
    vecs.push_back('{59, 0, 0, 200, 1, 0, 1, 0, 0});
    vecs.push_back('{60, 0, 0, 200, 0, 1, 0, 1, 1});
    vecs.push_back('{61, 0, 0, 200, 0, 1, 0, 0, 1});

    #2;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      while (cyc < v.cyc) step();
      cmd_valid = (v.valid != 0);
      cmd_pen_down = (v.down != 0);
      check_output($sformatf("vec%0d", i), v.pw, v.tick, v.ready, v.busy, v.done, v.pen);
      step();
      cmd_valid = 1'b0;
      cmd_pen_down = 1'b0;
    end

    // Pen up from down while cmd_valid stays high with a toggling direction.
    exp_up = '{160, 120, 80, 50};
    prev = DOWN_W;
    got_done = 0;
    cmd_valid = 1'b1;
    cmd_pen_down = 1'b0;
    for (int n = 0; n < 150 && got_done == 0; n++) begin
      check_model("up_ramp");
      if (int'(pulse_width) != prev) begin
        seen.push_back(int'(pulse_width));
        prev = int'(pulse_width);
      end
      if (done) got_done = 1;
      step();
      cmd_valid = (m_q.size() != 0);
      cmd_pen_down = ~cmd_pen_down;
    end
    cmd_valid = 1'b0;
    check_int("up_done_seen", got_done, 1);
    check_int("up_step_count", seen.size(), exp_up.size());
    for (int i = 0; i < exp_up.size() && i < seen.size(); i++)
      check_int($sformatf("up_step%0d", i), seen[i], exp_up[i]);
    check_output("up_final", UP_W, ((cyc % FRAME) == FRAME - 1) ? 1 : 0, 1, 0, 0, 0);

    // Pen up while already up completes at once.
    #2;
    do_reset();
    run_to("up_at_up_pre", 2);
    cmd_valid = 1'b1;
    cmd_pen_down = 1'b0;
    check_output("up_at_up_accept", UP_W, 0, 1, 0, 0, 0);
    step();
    cmd_valid = 1'b0;
    check_output("up_at_up_done", UP_W, 0, 1, 0, 1, 0);
    step();
    check_output("up_at_up_after", UP_W, 0, 1, 0, 0, 0);

    // Acceptance on a tick cycle, then reset in the middle of the ramp.
    #2;
    do_reset();
    run_to("tick_accept_pre", 9);
    cmd_valid = 1'b1;
    cmd_pen_down = 1'b1;
    check_output("accept_on_tick", UP_W, 1, 1, 0, 0, 0);
    step();
    cmd_valid = 1'b0;
    run_to("tick_accept_wait", 19);
    check_output("no_step_on_accept_tick", UP_W, 1, 0, 1, 0, 0);
    step();
    check_output("first_step_after_tick", 90, 0, 0, 1, 0, 0);
    run_to("mid_ramp", 32);
    check_output("mid_ramp_130", 130, 0, 0, 1, 0, 0);
    #2;
    do_reset();
    run_to("post_reset", 8);
    check_output("post_reset_c8", UP_W, 0, 1, 0, 0, 0);
    step();
    check_output("post_reset_tick", UP_W, 1, 1, 0, 0, 0);
    step();

    // Random commands and occasional resets against the model.
    #2;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        do_reset();
      end
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_pen_down = $urandom_range(0, 1) == 1;
      check_model("random");
      step();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pen_servo_ramp.md
Name: pen_servo_ramp

Overview:
- Command stage directly upstream of the pen-servo PWM generator.
- Accepts pen-up/pen-down commands from the processor over a valid/ready handshake.
- Slews the servo pulse width toward the target in fixed steps, once per PWM frame, then waits a settle interval and signals completion.
- Drives the generator's 20-bit high-time count (system-clock cycles per frame), so the pen moves smoothly and software knows when the pen has physically arrived.

Parameters:
SYS_FREQ, 50000000, system clock frequency in Hz
PWM_FREQ, 50, servo frame rate in Hz; FRAME = SYS_FREQ/PWM_FREQ clocks per frame
UP_WIDTH, 50000, pulse width in clocks for pen up (0 deg)
DOWN_WIDTH, 200000, pulse width in clocks for pen down
STEP, 10000, maximum width change per frame, in clocks; must be at least 1
SETTLE_FRAMES, 10, frames to wait after reaching the target; must be at least 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  input  1  command present
cmd_pen_down  input  1  1 = move pen down, 0 = move pen up; sampled when cmd_valid and cmd_ready are both high
cmd_ready  output  1  block can accept a command
pulse_width  output  20  current high-time count fed to the PWM generator
frame_tick  output  1  one-cycle pulse on the last clock of each frame
busy  output  1  ramp or settle in progress
done  output  1  one-cycle pulse when a command completes
pen_is_down  output  1  last completed pen position

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - pulse_width=UP_WIDTH, pen_is_down=0, state IDLE.
  - cmd_ready=1, busy=0, done=0, frame_tick=0.
  - Frame counter=0; settle counter=0.
- Frame counter:
  - Free-runs 0..FRAME-1 and wraps to 0.
  - frame_tick is registered and high while the counter equals FRAME-1, i.e. on clock cycles FRAME-1, 2*FRAME-1, ... after reset release.
  - pulse_width changes only on a frame_tick cycle, so the generator never sees a mid-frame change.
- Handshake:
  - A command is accepted on a rising edge when cmd_valid=1 and cmd_ready=1.
  - cmd_ready is 1 only in IDLE. Commands presented while busy are ignored, not queued.
  - Target = DOWN_WIDTH if cmd_pen_down=1, else UP_WIDTH; latched on acceptance.
- States:
  - IDLE:
    - On acceptance with target == pulse_width: stay IDLE, pulse done on the next cycle, set pen_is_down=cmd_pen_down with the done pulse.
    - On acceptance with target != pulse_width: go to RAMP; busy=1 and cmd_ready=0 from the next cycle.
  - RAMP: on each frame_tick, move pulse_width toward the target by STEP, clamped to the target:
    - If |target - pulse_width| <= STEP, pulse_width = target and go to SETTLE with settle counter = 0.
    - Otherwise pulse_width += STEP or -= STEP.
    - A frame_tick in the same cycle as acceptance does not step; the first step is on the next frame_tick.
  - SETTLE: the settle counter increments on each frame_tick. On the tick where it reaches SETTLE_FRAMES-1:
    - Next cycle: IDLE, done=1 for one cycle, busy=0, cmd_ready=1.
    - pen_is_down updates with the done pulse.
- Arithmetic:
  - All width arithmetic is 20-bit unsigned. The magnitude compare happens before any add or subtract, so no underflow or overflow occurs.
  - UP_WIDTH, DOWN_WIDTH and FRAME-1 must each fit in 20 bits.
- Busy and done:
  - busy = (state != IDLE).
  - done never coincides with busy=1.
- Reset mid-operation:
  - Asserting reset during RAMP or SETTLE returns pulse_width to UP_WIDTH immediately, without ramping.
  - Any in-flight command is discarded and no done pulse is produced.

Test Plan:
- Common settings unless stated: SYS_FREQ=1000, PWM_FREQ=100 (FRAME=10), UP_WIDTH=50, DOWN_WIDTH=200, STEP=40, SETTLE_FRAMES=2.
- Reset release, no command -> pulse_width=50, cmd_ready=1, busy=0, pen_is_down=0; frame_tick high on cycles 9, 19, 29.
- Pen-down command accepted at cycle 3 -> pulse_width sequence 90, 130, 170, 200 at ticks 9, 19, 29, 39 (final step clamped); settle ticks at 49 and 59; done pulse at cycle 60; then pen_is_down=1, cmd_ready=1.
- From pen down, a pen-up command -> 160, 120, 80, 50 (clamped), then settle and done; pen_is_down=0. Also, cmd_valid held during the ramp with cmd_pen_down toggling -> cmd_ready=0 and the target does not change.
- Pen-up command right after reset (target equals current width) -> no busy, done one cycle after acceptance, pulse_width stays 50.
- Command accepted on the same cycle as frame_tick (cycle 9) -> no step at 9; first step, to 90, at cycle 19.
- Reset asserted mid-ramp while pulse_width=130 -> pulse_width=50 asynchronously, busy=0, no done pulse; after release, frame_tick at 9 cycles after release.
